// File: rtl/expr_sig_collector_if.sv
// Result-vector stream between the expression stage and the signature collector.
//   in_valid : producer has a vector on y
//   in_ready : collector accepts the vector this cycle
//   y        : Y_W-bit result vector
// A transfer happens on a rising clock edge where in_valid & in_ready.
interface expr_sig_collector_if #(
  parameter int unsigned Y_W = 90
);
  logic           in_valid;
  logic           in_ready;
  logic [Y_W-1:0] y;

  modport master (output in_valid, output y, input in_ready);
  modport slave  (input in_valid, input y, output in_ready);
endinterface

// File: rtl/expr_sig_collector.sv
// expr_sig_collector
// Capture stage for the expression blocks. Each accepted Y_W-bit vector is
// folded to 32 bits in a registered stage. The folded value is then
// compacted into a MISR signature over a programmed number of vectors.
//
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   start        : pulse; begins a run (ignored while busy)
//   num_vectors  : vectors per run, latched on an accepted start
//   vin          : slave side of the vector stream (in_valid/in_ready/y)
//   busy         : run in progress (RUN or FLUSH)
//   done         : signature final; held until the next accepted start
//   vec_count    : vectors accepted in the current run
//   sig_out      : current signature
//   exp_sig/pass : only with EXPR_SIG_CMP_EN; pass = final signature matches exp_sig
//
// Optional feature macro: EXPR_SIG_CMP_EN
module expr_sig_collector #(
  parameter int unsigned      Y_W   = 90,
  parameter int unsigned      SIG_W = 32,
  parameter int unsigned      CNT_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_vectors,
  expr_sig_collector_if.slave   vin,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      vec_count,
  output logic [SIG_W-1:0]      sig_out
`ifdef EXPR_SIG_CMP_EN
  ,
  input  logic [SIG_W-1:0]      exp_sig,
  output logic                  pass
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] nv_q;
  logic [SIG_W-1:0] fold_q;
  logic             fv_q;
  logic             rdy;
  logic             hs;
  logic             start_acc;
  logic             last;
  logic [95:0]      ypad;
  logic [31:0]      fold_d;
  logic [SIG_W-1:0] sig_nxt;

  assign hs        = vin.in_valid && (state_q == RUN);
  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
  assign last      = (vec_count == nv_q - 1'b1);
  assign vin.in_ready = rdy;

  // Zero-pad the vector to three 32-bit lanes and XOR them together.
  always_comb begin
    ypad = '0;
    ypad[Y_W-1:0] = vin.y;
    fold_d = ypad[31:0] ^ ypad[63:32] ^ ypad[95:64];
  end

  assign sig_nxt = {sig_out[SIG_W-2:0], 1'b0}
                 ^ (sig_out[SIG_W-1] ? POLY : '0)
                 ^ fold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) state_d = (num_vectors == '0) ? DONE : RUN;
      end
      RUN: begin
        rdy  = 1'b1;
        busy = 1'b1;
        if (hs && last) state_d = FLUSH;
      end
      FLUSH: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_out   <= SEED;
      vec_count <= '0;
      nv_q      <= '0;
      fold_q    <= '0;
      fv_q      <= 1'b0;
    end else begin
      fv_q <= hs;
      if (hs) begin
        fold_q    <= SIG_W'(fold_d);
        vec_count <= vec_count + 1'b1;
      end
      // start is only accepted in IDLE/DONE, where no fold is ever pending,
      // so reseeding never collides with a MISR update.
      if (start_acc) begin
        sig_out   <= SEED;
        vec_count <= '0;
        nv_q      <= num_vectors;
      end else if (fv_q) begin
        sig_out <= sig_nxt;
      end
    end
  end

`ifdef EXPR_SIG_CMP_EN
  // The last MISR update lands on the same edge as FLUSH->DONE, so the
  // comparison uses the value being written rather than the stale register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   pass <= 1'b0;
    else if (start_acc)        pass <= 1'b0;
    else if (state_q == FLUSH) pass <= (sig_nxt == exp_sig);
  end
`endif

endmodule
